// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back entry layout.
package cpu_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// Youngest-match search over the valid write-back entries for one forwarding address.
module wb_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PW-1:0]          rd_ptr,
  input  logic [REG_ADDR_W-1:0]  addr,
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] slot;
    logic          match;
    hit  = 1'b0;
    data = {DATA_W{1'b0}};
    slot = {PW{1'b0}};
    match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      slot  = rd_ptr + PW'(k);
      match = valid[slot] && (entries[slot].dst == addr);
      hit   = hit | match;
      data  = match ? entries[slot].data : data;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register-file write port, with pending
// scoreboard and two youngest-value forwarding lookups.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_reg,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    drain_en,
  input  logic                    flush,
  output logic                    write_en,
  output logic [ADDR_W-1:0]       wreg,
  output logic [DATA_W-1:0]       writedata,
  output logic [(2**ADDR_W)-1:0]  pending,
  input  logic [ADDR_W-1:0]       fwd_addr_a,
  input  logic [ADDR_W-1:0]       fwd_addr_b,
  output logic                    fwd_hit_a,
  output logic                    fwd_hit_b,
  output logic [DATA_W-1:0]       fwd_data_a,
  output logic [DATA_W-1:0]       fwd_data_b,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**ADDR_W;

  cpu_pkg::wb_entry_t mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [DEPTH-1:0]   valid_s;
  logic [NR-1:0]      pending_s;
  logic               push_s;
  logic               pop_s;

  // No pass-through: a full queue refuses pushes even when it drains this cycle.
  assign in_ready = (count_r < CW'(DEPTH));
  assign pop_s    = drain_en && (count_r != {CW{1'b0}});
  assign push_s   = in_valid && in_ready && !flush;
  assign write_en = pop_s;
  assign count    = count_r;
  assign pending  = pending_s;

  // Head entry presented to the register file, zero when empty.
  always_comb begin
    wreg      = {ADDR_W{1'b0}};
    writedata = {DATA_W{1'b0}};
    if (count_r != {CW{1'b0}}) begin
      wreg      = mem_r[rd_ptr_r].dst;
      writedata = mem_r[rd_ptr_r].data;
    end else begin
      wreg      = {ADDR_W{1'b0}};
      writedata = {DATA_W{1'b0}};
    end
  end

  // Slot validity by age relative to the head, and the per-register pending map.
  always_comb begin
    logic [PW-1:0] age;
    valid_s   = {DEPTH{1'b0}};
    pending_s = {NR{1'b0}};
    age       = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      age        = PW'(i) - rd_ptr_r;
      valid_s[i] = ({1'b0, age} < count_r);
      pending_s[mem_r[i].dst] = pending_s[mem_r[i].dst] | valid_s[i];
    end
  end

  // Queue state: flush wins over push, but the head still commits that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{dst: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
      end
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{dst: in_reg, data: in_data};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  wb_match #(.DEPTH(DEPTH)) u_match_a (
    .entries (mem_r),
    .valid   (valid_s),
    .rd_ptr  (rd_ptr_r),
    .addr    (fwd_addr_a),
    .hit     (fwd_hit_a),
    .data    (fwd_data_a)
  );

  wb_match #(.DEPTH(DEPTH)) u_match_b (
    .entries (mem_r),
    .valid   (valid_s),
    .rd_ptr  (rd_ptr_r),
    .addr    (fwd_addr_b),
    .hit     (fwd_hit_b),
    .data    (fwd_data_b)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: scoreboard queue of expected commits plus a
// register-file and forwarding model.
module tb_wb_queue;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic        flush;
  logic        write_en;
  logic [2:0]  wreg;
  logic [15:0] writedata;
  logic [7:0]  pending;
  logic [2:0]  fwd_addr_a;
  logic [2:0]  fwd_addr_b;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [15:0] fwd_data_a;
  logic [15:0] fwd_data_b;
  logic [2:0]  count;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg     (in_reg),
    .in_data    (in_data),
    .drain_en   (drain_en),
    .flush      (flush),
    .write_en   (write_en),
    .wreg       (wreg),
    .writedata  (writedata),
    .pending    (pending),
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of queued {reg, data} in request order, plus register-file models.
  logic [18:0] mq [$];
  logic [15:0] m_rf   [8];
  logic [15:0] dut_rf [8];

  logic        m_commit, m_accept, m_flush;
  logic [18:0] m_entry;
  logic        obs_we;
  logic [2:0]  obs_reg;
  logic [15:0] obs_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] fwd_model(input logic [2:0] a);
    logic [16:0] r;
    r = 17'h0;
    foreach (mq[i]) begin
      if (mq[i][18:16] == a) r = {1'b1, mq[i][15:0]};
    end
    return r;
  endfunction

  function automatic logic [7:0] pending_model();
    logic [7:0] p;
    p = 8'h0;
    foreach (mq[i]) p[mq[i][18:16]] = 1'b1;
    return p;
  endfunction

  // Drive one cycle's inputs, then check every output against the model mid-cycle.
  task automatic cyc_a(input logic v, input logic [2:0] r, input logic [15:0] d,
                       input logic de, input logic fl, input logic [2:0] fa, input logic [2:0] fb);
    logic [16:0] fw;
    in_valid = v; in_reg = r; in_data = d; drain_en = de; flush = fl;
    fwd_addr_a = fa; fwd_addr_b = fb;
    @(negedge clk);
    check_eq("write_en", 32'(write_en), 32'(de && (mq.size() != 0)));
    if (mq.size() != 0) begin
      check_eq("wreg", 32'(wreg), 32'(mq[0][18:16]));
      check_eq("writedata", 32'(writedata), 32'(mq[0][15:0]));
    end else begin
      check_eq("wreg_empty", 32'(wreg), 32'h0);
      check_eq("writedata_empty", 32'(writedata), 32'h0);
    end
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check_eq("pending", 32'(pending), 32'(pending_model()));
    fw = fwd_model(fa);
    check_eq("fwd_hit_a", 32'(fwd_hit_a), 32'(fw[16]));
    check_eq("fwd_data_a", 32'(fwd_data_a), 32'(fw[15:0]));
    fw = fwd_model(fb);
    check_eq("fwd_hit_b", 32'(fwd_hit_b), 32'(fw[16]));
    check_eq("fwd_data_b", 32'(fwd_data_b), 32'(fw[15:0]));
    obs_we = write_en; obs_reg = wreg; obs_data = writedata;
    m_commit = de && (mq.size() != 0);
    m_accept = v && (mq.size() < DEPTH) && !fl;
    m_flush  = fl;
    m_entry  = {r, d};
  endtask

  // Clock edge: apply the DUT's observed commit and advance the model.
  task automatic cyc_b();
    logic [18:0] e;
    @(posedge clk);
    #1;
    if (obs_we) dut_rf[obs_reg] = obs_data;
    if (m_commit) begin
      e = mq.pop_front();
      m_rf[e[18:16]] = e[15:0];
    end
    if (m_flush) mq.delete();
    else if (m_accept) mq.push_back(m_entry);
  endtask

  task automatic cyc(input logic v, input logic [2:0] r, input logic [15:0] d,
                     input logic de, input logic fl, input logic [2:0] fa, input logic [2:0] fb);
    cyc_a(v, r, d, de, fl, fa, fb);
    cyc_b();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_rf[i] = 16'h0; dut_rf[i] = 16'h0; end
    rst_n = 1'b0; in_valid = 1'b0; in_reg = 3'd0; in_data = 16'h0;
    drain_en = 1'b1; flush = 1'b0; fwd_addr_a = 3'd0; fwd_addr_b = 3'd0;
    obs_we = 1'b0; obs_reg = 3'd0; obs_data = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst_write_en", 32'(write_en), 32'h0);
    check_eq("rst_pending", 32'(pending), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single push drained immediately.
    cyc(1'b1, 3'd2, 16'h1234, 1'b1, 1'b0, 3'd2, 3'd0);
    cyc_a(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd2, 3'd0);
    check_eq("t1_we", 32'(write_en), 32'h1);
    check_eq("t1_wreg", 32'(wreg), 32'h2);
    check_eq("t1_wdata", 32'(writedata), 32'h1234);
    check_eq("t1_pending", 32'(pending), 32'h04);
    cyc_b();
    cyc_a(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd2, 3'd0);
    check_eq("t1_count0", 32'(count), 32'h0);
    check_eq("t1_pending0", 32'(pending), 32'h0);
    cyc_b();

    // Fill without draining; youngest r3 must forward.
    cyc(1'b1, 3'd3, 16'h0001, 1'b0, 1'b0, 3'd3, 3'd5);
    cyc(1'b1, 3'd5, 16'h0002, 1'b0, 1'b0, 3'd3, 3'd5);
    cyc(1'b1, 3'd3, 16'h0003, 1'b0, 1'b0, 3'd3, 3'd5);
    cyc(1'b1, 3'd1, 16'h0004, 1'b0, 1'b0, 3'd3, 3'd1);
    cyc_a(1'b1, 3'd7, 16'h5555, 1'b0, 1'b0, 3'd3, 3'd7);
    check_eq("t2_count", 32'(count), 32'h4);
    check_eq("t2_in_ready", 32'(in_ready), 32'h0);
    check_eq("t2_pending", 32'(pending), 32'h2A);
    check_eq("t2_hit_a", 32'(fwd_hit_a), 32'h1);
    check_eq("t2_data_a", 32'(fwd_data_a), 32'h0003);
    cyc_b();
    cyc_a(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd7, 3'd0);
    check_eq("t2_refused", 32'(count), 32'h4);
    cyc_b();

    // Full with drain: push refused; then push and drain together.
    cyc_a(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0, 3'd6, 3'd3);
    check_eq("t3_we", 32'(write_en), 32'h1);
    check_eq("t3_in_ready", 32'(in_ready), 32'h0);
    cyc_b();
    cyc_a(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0, 3'd6, 3'd3);
    check_eq("t3_count3", 32'(count), 32'h3);
    cyc_b();
    cyc_a(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd6, 3'd5);
    check_eq("t3_count_still3", 32'(count), 32'h3);
    check_eq("t3_hit6", 32'(fwd_data_a), 32'h6666);
    cyc_b();

    // Flush with a simultaneous push.
    cyc(1'b1, 3'd7, 16'h7777, 1'b0, 1'b1, 3'd7, 3'd3);
    cyc_a(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd7, 3'd3);
    check_eq("t4_count", 32'(count), 32'h0);
    check_eq("t4_pending", 32'(pending), 32'h0);
    check_eq("t4_no_r7", 32'(fwd_hit_a), 32'h0);
    cyc_b();

    // Asynchronous reset in the middle of draining two entries.
    cyc(1'b1, 3'd4, 16'hAAAA, 1'b0, 1'b0, 3'd4, 3'd0);
    cyc(1'b1, 3'd0, 16'hBBBB, 1'b0, 1'b0, 3'd4, 3'd0);
    cyc_a(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd4, 3'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t5_we", 32'(write_en), 32'h0);
    check_eq("t5_wreg", 32'(wreg), 32'h0);
    check_eq("t5_wdata", 32'(writedata), 32'h0);
    check_eq("t5_count", 32'(count), 32'h0);
    check_eq("t5_pending", 32'(pending), 32'h0);
    check_eq("t5_in_ready", 32'(in_ready), 32'h1);
    check_eq("t5_hit_a", 32'(fwd_hit_a), 32'h0);
    check_eq("t5_data_a", 32'(fwd_data_a), 32'h0);
    mq.delete();
    @(negedge clk);
    check_eq("t5_we_held", 32'(write_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 3),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    // Drain whatever is left, then compare register files.
    for (int n = 0; n < DEPTH + 2; n++) begin
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 3'd1);
    end
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("rf%0d", i), 32'(dut_rf[i]), 32'(m_rf[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that buffers register-write requests from the execute/memory stages and drains them into the 8x16 register file's single write port. Acts as the initiator on the register file's write interface (write_en/wreg/writedata) and provides a per-register pending scoreboard plus two forwarding lookups, so the decode stage can read the newest value before it reaches the register file. Sits between the pipeline back end and the register file; depth is small, in-order, one push and one drain per cycle.

## Interface
- DEPTH, 4, number of queue entries (power of two, >= 2)
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  write request present
- in_ready  output  1  queue can accept; high when count < DEPTH
- in_reg  input  ADDR_W  destination register of request
- in_data  input  DATA_W  data to write
- drain_en  input  1  register-file write port available this cycle
- flush  input  1  synchronous discard of all queued entries
- write_en  output  1  to register file: commit head entry this edge
- wreg  output  ADDR_W  to register file: head destination, 0 when empty
- writedata  output  DATA_W  to register file: head data, 0 when empty
- pending  output  2**ADDR_W  bit r set while any queued entry targets register r
- fwd_addr_a, fwd_addr_b  input  ADDR_W  decode-stage read addresses
- fwd_hit_a, fwd_hit_b  output  1  a queued entry targets the address
- fwd_data_a, fwd_data_b  output  DATA_W  data of youngest matching entry, 0 on miss
- count  output  $clog2(DEPTH)+1  entries held

## Operation
- Circular buffer: wr_ptr, rd_ptr, count; entries hold {reg, data}.
- Push when in_valid && in_ready; entry written at wr_ptr, wr_ptr increments modulo DEPTH.
- write_en = drain_en && count != 0 (combinational from registered state). Pop at the same edge the register file commits.
- Push and pop in same cycle: count unchanged, both pointers advance. Full queue with pop: in_ready stays low that cycle (no pass-through).
- pending, fwd_*: combinational over valid entries only. Multiple matches: youngest (closest to wr_ptr) wins. Head entry being written this cycle still counts as pending/hit.
- flush: next edge count=0, ptrs=0; a simultaneous push is dropped; write_en in the flush cycle still follows drain_en/count (head committed).
- Register 0 is an ordinary register; no write suppression.
- Reset (rst_n low, any time): count=0, pointers=0, write_en=0, wreg=0, writedata=0, pending=0, fwd_hit_*=0, fwd_data_*=0, in_ready=1. Queued writes are lost.

## Timing
- Entry pushed at edge E: visible on pending/fwd from cycle after E; earliest write_en in that same cycle; register-file read returns new value the cycle after the commit edge.
- No bubble in hazard coverage: pending[r] drops at the same edge the register file latches r.
- Throughput: one push and one commit per cycle sustained.
- No combinational path from in_valid/in_data to any output.

## Structure
- Shared package cpu_pkg: REG_ADDR_W=3, DATA_W=16, NUM_REGS=8, wb_entry_t struct {reg, data}.
- One sub-module: wb_match, youngest-match search (entries, valid mask, rd_ptr, address -> hit, data), instantiated twice for ports a and b.

## Test plan
- Reset then push {r2,0x1234} with drain_en=1 -> next cycle write_en=1, wreg=2, writedata=0x1234, pending=0x04; following cycle count=0, pending=0.
- drain_en=0, push r3=0x0001, r5=0x0002, r3=0x0003, r1=0x0004 -> count=4, in_ready=0, pending=0x2A, fwd_addr_a=3 gives hit=1 data=0x0003; 5th push not accepted.
- Full queue, drain_en=1 and in_valid=1 -> one commit, push refused, count=3; next cycle push accepted, count stays 3 while draining.
- Queue holding 3 entries, flush=1 with in_valid=1 -> next cycle count=0, pending=0, pushed entry absent.
- rst_n low mid-drain with 2 entries -> outputs go to reset values immediately, no further write_en.
- Random push/drain traffic against reference model: register-file contents and commit order match request order; fwd data always equals youngest queued value.
